// File: rtl/pll_ctrl.sv
// pll_ctrl -- sequencing controller for the on-chip Gowin PLL.
//
// Runs on the PLL reference clock. Holds the PLL in reset, waits for LOCK,
// qualifies LOCK over a stable window and only then releases the user reset.
// Failed lock attempts are retried up to MAX_RETRY times before FAULT.
// Divider selects can be changed at run time through cfg_req/cfg_ack.
//
// Optional feature macro: PLL_CTRL_AUTO_RELOCK_EN
//   defined   : lock loss in RUN restarts the full relock sequence.
//   undefined : lock loss in RUN goes to FAULT (leave via cfg_req or reset).
//
// Ports:
//   sys_clk      in   reference clock (also the PLL input clock)
//   sys_rst_n    in   asynchronous active-low reset
//   pll_lock     in   PLL LOCK, asynchronous to sys_clk
//   cfg_req      in   level request for new selects, held until cfg_ack
//   cfg_idsel/cfg_fbdsel/cfg_odsel  in [5:0]  requested selects
//   cfg_ack      out  one-cycle pulse when the requested config is qualified
//   pll_reset    out  PLL RESET, active high
//   pll_idsel/pll_fbdsel/pll_odsel  out [5:0]  selects to the PLL
//   clk_ok       out  high only in RUN
//   user_rst_n   out  active-low reset for PLL-clocked logic, low outside RUN
//   fault        out  high in FAULT
//   retry_cnt    out [3:0]  failed attempts in the current sequence
//   state_dbg    out [2:0]  current FSM state, for observation only
//
// Handshake: cfg_req is a level held by the requester. It is accepted only
// in RUN or FAULT (selects latched on that edge, PLL reset reasserted next
// cycle); elsewhere it simply stays pending on the level. cfg_ack pulses for
// one cycle on the RUN entry that follows an accepted request; the requester
// drops cfg_req once it sees cfg_ack.
module pll_ctrl #(
    parameter int         RST_HOLD    = 12,
    parameter int         LOCK_WAIT   = 24000,
    parameter int         LOCK_STABLE = 1200,
    parameter int         MAX_RETRY   = 3,
    parameter logic [5:0] INIT_IDSEL  = 6'd0,
    parameter logic [5:0] INIT_FBDSEL = 6'd0,
    parameter logic [5:0] INIT_ODSEL  = 6'd0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       user_rst_n,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_QUALIFY   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // One shared down-counter, sized for the longest interval.
    localparam int CNT_MAX_A = (LOCK_WAIT > LOCK_STABLE) ? LOCK_WAIT : LOCK_STABLE;
    localparam int CNT_MAX   = (CNT_MAX_A > RST_HOLD) ? CNT_MAX_A : RST_HOLD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    // Counters load N-1 so that a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_WAIT   = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       retry_n;
    logic [3:0]       retry_inc;
    logic             pending, pending_n;
    logic             ack_n;
    logic             accept;
    logic             lock_m, lock_s;

    assign retry_inc = retry_cnt + 4'd1;
    assign state_dbg = state;

    // Two-flop synchronizer for the asynchronous LOCK.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        retry_n   = retry_cnt;
        pending_n = pending;
        ack_n     = 1'b0;
        accept    = 1'b0;

        case (state)
            S_HOLD: begin
                if (cnt == CNT_ZERO) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = LD_WAIT;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end

            S_WAIT_LOCK: begin
                // A lock seen on the last cycle of the window still counts.
                if (lock_s) begin
                    state_n = S_QUALIFY;
                    cnt_n   = LD_STABLE;
                end else if (cnt == CNT_ZERO) begin
                    retry_n = retry_inc;
                    if (retry_inc == RETRY_LIM) begin
                        state_n = S_FAULT;
                        cnt_n   = LD_HOLD;
                    end else begin
                        state_n = S_HOLD;
                        cnt_n   = LD_HOLD;
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end

            S_QUALIFY: begin
                // Any low cycle restarts the wait without costing a retry.
                if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = LD_WAIT;
                end else if (cnt == CNT_ZERO) begin
                    state_n   = S_RUN;
                    retry_n   = 4'd0;
                    ack_n     = pending;
                    pending_n = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end

            S_RUN: begin
                // A request in the same cycle as lock loss takes priority.
                if (cfg_req) begin
                    accept = 1'b1;
                end else if (!lock_s) begin
`ifdef PLL_CTRL_AUTO_RELOCK_EN
                    state_n = S_HOLD;
                    cnt_n   = LD_HOLD;
                    retry_n = 4'd0;
`else
                    state_n = S_FAULT;
                    cnt_n   = LD_HOLD;
`endif
                end
            end

            S_FAULT: begin
                if (cfg_req) begin
                    accept = 1'b1;
                end
            end

            default: begin
                state_n = S_HOLD;
                cnt_n   = LD_HOLD;
            end
        endcase

        if (accept) begin
            state_n   = S_HOLD;
            cnt_n     = LD_HOLD;
            pending_n = 1'b1;
            retry_n   = 4'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_HOLD;
            cnt       <= LD_HOLD;
            retry_cnt <= 4'd0;
            pending   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            pending   <= pending_n;
        end
    end

    // Outputs are registered from the next state so they are valid in the
    // first cycle of each state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pll_reset  <= 1'b1;
            clk_ok     <= 1'b0;
            user_rst_n <= 1'b0;
            fault      <= 1'b0;
            cfg_ack    <= 1'b0;
            pll_idsel  <= INIT_IDSEL;
            pll_fbdsel <= INIT_FBDSEL;
            pll_odsel  <= INIT_ODSEL;
        end else begin
            pll_reset  <= (state_n == S_HOLD) || (state_n == S_FAULT);
            clk_ok     <= (state_n == S_RUN);
            user_rst_n <= (state_n == S_RUN);
            fault      <= (state_n == S_FAULT);
            cfg_ack    <= ack_n;
            if (accept) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl: a phase/elapsed-time reference model is
// compared with every DUT output on each falling clock edge, and directed
// scenarios pin key latencies with hand-computed literals.
module tb_pll_ctrl;

    localparam int         RH   = 12;
    localparam int         LW   = 2000;
    localparam int         LS   = 1200;
    localparam int         MR   = 3;
    localparam logic [5:0] I_ID = 6'd3;
    localparam logic [5:0] I_FB = 6'd7;
    localparam logic [5:0] I_OD = 6'd11;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       pll_lock   = 1'b0;
    logic       cfg_req    = 1'b0;
    logic [5:0] cfg_idsel  = 6'd0;
    logic [5:0] cfg_fbdsel = 6'd0;
    logic [5:0] cfg_odsel  = 6'd0;
    logic       cfg_ack, pll_reset, clk_ok, user_rst_n, fault;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [3:0] retry_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cnt  = 0;

    pll_ctrl #(
        .RST_HOLD(RH), .LOCK_WAIT(LW), .LOCK_STABLE(LS), .MAX_RETRY(MR),
        .INIT_IDSEL(I_ID), .INIT_FBDSEL(I_FB), .INIT_ODSEL(I_OD)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
        .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel(cfg_odsel), .cfg_ack(cfg_ack), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .clk_ok(clk_ok), .user_rst_n(user_rst_n), .fault(fault),
        .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Phases of the sequence; elapsed counts cycles spent in the phase.
    localparam int M_HOLD = 0, M_WAIT = 1, M_QUAL = 2, M_RUN = 3, M_FAULT = 4;
    int         m_ph    = M_HOLD;
    int         m_el    = 0;
    int         m_retry = 0;
    bit         m_pend  = 1'b0;
    bit         m_ack   = 1'b0;
    bit         sync_q[$] = '{1'b0, 1'b0};
    logic [5:0] m_id = I_ID, m_fb = I_FB, m_od = I_OD;

    function automatic void enter(int ph);
        m_ph = ph;
        m_el = 0;
    endfunction

    function automatic void m_accept();
        m_id   = cfg_idsel;
        m_fb   = cfg_fbdsel;
        m_od   = cfg_odsel;
        m_pend = 1'b1;
        m_retry = 0;
        enter(M_HOLD);
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            enter(M_HOLD);
            m_retry = 0;
            m_pend  = 1'b0;
            m_ack   = 1'b0;
            m_id    = I_ID;
            m_fb    = I_FB;
            m_od    = I_OD;
            sync_q  = '{1'b0, 1'b0};
        end else begin
            bit ls;
            // LOCK as seen by the FSM: the pin value from two edges ago.
            ls = sync_q.pop_front();
            sync_q.push_back(pll_lock);
            m_ack = 1'b0;
            case (m_ph)
                M_HOLD: begin
                    m_el++;
                    if (m_el == RH) enter(M_WAIT);
                end
                M_WAIT: begin
                    if (ls) enter(M_QUAL);
                    else begin
                        m_el++;
                        if (m_el == LW) begin
                            m_retry++;
                            enter((m_retry == MR) ? M_FAULT : M_HOLD);
                        end
                    end
                end
                M_QUAL: begin
                    if (!ls) enter(M_WAIT);
                    else begin
                        m_el++;
                        if (m_el == LS) begin
                            enter(M_RUN);
                            m_retry = 0;
                            m_ack   = m_pend;
                            m_pend  = 1'b0;
                        end
                    end
                end
                M_RUN: begin
                    if (cfg_req) m_accept();
                    else if (!ls) begin
                        if (AUTO) begin
                            enter(M_HOLD);
                            m_retry = 0;
                        end else begin
                            enter(M_FAULT);
                        end
                    end
                end
                default: begin
                    if (cfg_req) m_accept();
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, state_dbg %0d)",
                     nm, act, exp_v, cyc, state_dbg);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    always @(negedge sys_clk) begin
        if (cfg_ack === 1'b1) ack_cnt++;
        chk("m_cfg_ack",    cfg_ack,    m_ack);
        chk("m_pll_reset",  pll_reset,  (m_ph == M_HOLD || m_ph == M_FAULT));
        chk("m_clk_ok",     clk_ok,     (m_ph == M_RUN));
        chk("m_user_rst_n", user_rst_n, (m_ph == M_RUN));
        chk("m_fault",      fault,      (m_ph == M_FAULT));
        chk("m_retry_cnt",  retry_cnt,  m_retry);
        chk("m_idsel",      pll_idsel,  m_id);
        chk("m_fbdsel",     pll_fbdsel, m_fb);
        chk("m_odsel",      pll_odsel,  m_od);
    end

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the posedge that makes cyc == target.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return clk_ok;
            1:       return fault;
            default: return cfg_ack;
        endcase
    endfunction

    task automatic wait_high(input int sel, input string nm, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (sig_of(sel) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still low after %0d cycles, required 1", nm, budget);
        end
    endtask

    // Reset for a few cycles; returns the cycle of the last edge in reset.
    task automatic do_reset(input logic lock_v, output int c0);
        sys_rst_n = 1'b0;
        cfg_req   = 1'b0;
        pll_lock  = lock_v;
        goto(cyc + 3);
        sys_rst_n = 1'b1;
        c0 = cyc;
    endtask

    task automatic request(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        cfg_idsel  = id;
        cfg_fbdsel = fb;
        cfg_odsel  = od;
        cfg_req    = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, t, a, a0;

        // Reset state
        goto(2);
        @(negedge sys_clk);
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_idsel", pll_idsel, I_ID);
        chk("rst_user_rst_n", user_rst_n, 0);

        // Startup, lock 100 cycles after pll_reset falls
        do_reset(1'b0, c0);
        goto(c0 + 11);
        @(negedge sys_clk);
        chk("hold_last_cycle", pll_reset, 1);
        goto(c0 + 12);
        @(negedge sys_clk);
        chk("hold_released", pll_reset, 0);
        goto(c0 + 112);
        pll_lock = 1'b1;
        wait_high(0, "startup_run", 1500, t);
        chk_rng("startup_latency", t - c0, RH + 100 + 3 + LS - 1, RH + 100 + 3 + LS + 1);
        chk("startup_retry", retry_cnt, 0);
        chk("startup_user_rst_n", user_rst_n, 1);

        // Reconfiguration from RUN
        goto(cyc + 5);
        a0 = ack_cnt;
        request(6'd5, 6'd9, 6'd60);
        a = cyc + 1;
        goto(a);
        @(negedge sys_clk);
        chk("cfg_idsel_applied", pll_idsel, 5);
        chk("cfg_fbdsel_applied", pll_fbdsel, 9);
        chk("cfg_odsel_applied", pll_odsel, 60);
        chk("cfg_pll_reset", pll_reset, 1);
        wait_high(2, "cfg_ack", 1500, t);
        cfg_req = 1'b0;
        chk("cfg_ack_latency", t - a, RH + 1 + LS);
        goto(cyc + 20);
        chk("cfg_ack_single", ack_cnt - a0, 1);

        // Lock loss in RUN
        pll_lock = 1'b0;
        a = cyc;
        goto(a + 2);
        @(negedge sys_clk);
        chk("loss_clk_ok_still", clk_ok, 1);
        goto(a + 3);
        @(negedge sys_clk);
        chk("loss_clk_ok_drop", clk_ok, 0);
        chk("loss_user_rst_n", user_rst_n, 0);
        chk("loss_pll_reset", pll_reset, 1);
        chk("loss_fault", fault, !AUTO);
        goto(cyc + 4);
        pll_lock = 1'b1;
        if (!AUTO) begin
            goto(cyc + 2);
            request(6'd17, 6'd33, 6'd2);
            wait_high(2, "fault_recover_ack", 1500, t);
            cfg_req = 1'b0;
            chk("fault_recover_idsel", pll_idsel, 17);
        end else begin
            wait_high(0, "relock_run", 1500, t);
        end
        chk("recover_clk_ok", clk_ok, 1);
        chk("recover_fault", fault, 0);

        // Reset during QUALIFY with a request pending
        goto(cyc + 5);
        a0 = ack_cnt;
        request(6'd1, 6'd2, 6'd4);
        a = cyc + 1;
        goto(a + 300);
        sys_rst_n = 1'b0;
        cfg_req   = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_pll_reset", pll_reset, 1);
        chk("mid_rst_idsel", pll_idsel, I_ID);
        chk("mid_rst_odsel", pll_odsel, I_OD);
        chk("mid_rst_ack", cfg_ack, 0);
        goto(cyc + 3);
        sys_rst_n = 1'b1;
        wait_high(0, "post_rst_run", 1500, t);
        goto(cyc + 5);
        chk("no_ack_after_reset", ack_cnt - a0, 0);

        // No lock at all: three attempts then FAULT
        do_reset(1'b0, c0);
        goto(c0 + 2011);
        @(negedge sys_clk);
        chk("retry0_pll_reset", pll_reset, 0);
        chk("retry0", retry_cnt, 0);
        goto(c0 + 2012);
        @(negedge sys_clk);
        chk("retry1", retry_cnt, 1);
        chk("retry1_pll_reset", pll_reset, 1);
        goto(c0 + 4024);
        @(negedge sys_clk);
        chk("retry2", retry_cnt, 2);
        wait_high(1, "fault_rise", 2100, t);
        chk("fault_time", t - c0, 3 * (RH + LW));
        chk("fault_retry", retry_cnt, MR);
        goto(cyc + 50);
        @(negedge sys_clk);
        chk("fault_sticky", fault, 1);
        chk("fault_pll_reset", pll_reset, 1);

        // One-cycle glitch 600 cycles into QUALIFY
        do_reset(1'b0, c0);
        goto(c0 + 112);
        pll_lock = 1'b1;
        goto(c0 + 715);
        pll_lock = 1'b0;
        goto(c0 + 716);
        pll_lock = 1'b1;
        goto(c0 + 1315);
        @(negedge sys_clk);
        chk("glitch_not_run_yet", clk_ok, 0);
        wait_high(0, "glitch_run", 1000, t);
        chk("glitch_run_time", t - c0, 1919);
        chk("glitch_retry", retry_cnt, 0);

        // Randomized phase, checked by the model every cycle
        do_reset(1'b1, c0);
        for (int seg = 0; seg < 14; seg++) begin
            case ($urandom_range(0, 5))
                0: begin
                    pll_lock = 1'b0;
                    goto(cyc + $urandom_range(1, 4));
                    pll_lock = 1'b1;
                end
                1: begin
                    pll_lock = 1'b1;
                    goto(cyc + $urandom_range(50, 1400));
                end
                2: begin
                    pll_lock = 1'b0;
                    goto(cyc + $urandom_range(20, 600));
                    pll_lock = 1'($urandom_range(0, 1));
                end
                3: begin
                    pll_lock = 1'b1;
                    request(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                            6'($urandom_range(0, 63)));
                    wait_high(2, "rand_cfg_ack", 3000, t);
                    cfg_req = 1'b0;
                    goto(cyc + $urandom_range(2, 30));
                end
                4: begin
                    sys_rst_n = 1'b0;
                    goto(cyc + $urandom_range(1, 3));
                    sys_rst_n = 1'b1;
                    goto(cyc + $urandom_range(5, 200));
                end
                default: begin
                    pll_lock = 1'b0;
                    goto(cyc + $urandom_range(500, 2500));
                    pll_lock = 1'b1;
                end
            endcase
        end

        goto(cyc + 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

PLL sequencing controller for the on-chip Gowin PLL. Runs on the PLL reference clock, drives the PLL reset and dynamic divider selects, qualifies the asynchronous LOCK output, and releases a synchronous user reset only once the PLL output is stable. It also retries failed lock attempts and applies run-time divider reconfiguration through a request/acknowledge handshake.

## Interface
Parameters:
- RST_HOLD, 12: cycles `pll_reset` is held high per attempt (≥1).
- LOCK_WAIT, 24000: cycles allowed for first LOCK after reset release (2 ms at 12 MHz).
- LOCK_STABLE, 1200: consecutive locked cycles required before run (100 µs).
- MAX_RETRY, 3: failed attempts before FAULT (1..15).
- INIT_IDSEL / INIT_FBDSEL / INIT_ODSEL, 6'd0: divider selects applied after reset.

Ports:
- sys_clk  in  1  reference clock; PLL input clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to sys_clk.
- cfg_req  in  1  level request to apply new selects; held until `cfg_ack`.
- cfg_idsel / cfg_fbdsel / cfg_odsel  in  6 each  requested selects, sampled on acceptance.
- cfg_ack  out  1  one-cycle pulse: requested config locked and qualified.
- pll_reset  out  1  PLL RESET, active high.
- pll_idsel / pll_fbdsel / pll_odsel  out  6 each  to PLL IDSEL/FBDSEL/ODSEL.
- clk_ok  out  1  high only in RUN.
- user_rst_n  out  1  active-low reset for PLL-clocked logic; low outside RUN.
- fault  out  1  high in FAULT.
- retry_cnt  out  4  failed attempts in current sequence.

## Operation
- `pll_lock` passes a 2-flop synchronizer → `lock_s`. One down-counter (width for max(LOCK_WAIT, LOCK_STABLE, RST_HOLD)) shared by all states; reloaded on each state entry.
- States: HOLD, WAIT_LOCK, QUALIFY, RUN, FAULT. Reset state HOLD.
- HOLD: `pll_reset`=1 for RST_HOLD cycles → WAIT_LOCK.
- WAIT_LOCK: `lock_s`=1 → QUALIFY. LOCK_WAIT expiry → retry_cnt+1; if new value == MAX_RETRY → FAULT, else → HOLD.
- QUALIFY: `lock_s` low any cycle → WAIT_LOCK (fresh LOCK_WAIT, no retry increment). LOCK_STABLE consecutive high cycles → RUN; retry_cnt cleared; `cfg_ack` pulses on entry if a request was accepted in this sequence.
- RUN: `clk_ok`=1, `user_rst_n`=1. `cfg_req`=1 → latch cfg_* into pll_* selects, mark request pending, retry_cnt←0, → HOLD. Lock loss: see Configuration.
- FAULT: `fault`=1, `pll_reset`=1. Only `cfg_req` (accepted as in RUN) or `sys_rst_n` leaves it.
- `cfg_req` outside RUN/FAULT is ignored (stays pending on the level). `cfg_req` and lock loss in the same RUN cycle: request wins (both lead to HOLD; new selects applied).
- Selects change only on the acceptance edge, always while `pll_reset` goes high the next cycle.

## Timing
- All outputs registered, decoded from next-state; valid the cycle state is entered.
- Reset values: pll_reset=1, selects=INIT_*, clk_ok=0, user_rst_n=0, fault=0, cfg_ack=0, retry_cnt=0.
- `pll_lock` rise → QUALIFY entry: 3 cycles (2 sync + 1 register).
- Nominal startup, immediate lock: RST_HOLD + 3 + LOCK_STABLE cycles to `user_rst_n`=1.
- Lock loss in RUN: `clk_ok`/`user_rst_n` drop 3 cycles after `pll_lock` falls.
- `sys_rst_n` low mid-sequence: immediate return to reset values, pending request discarded.

## Configuration
- PLL_CTRL_AUTO_RELOCK_EN defined: `lock_s` low in RUN → HOLD, retry_cnt←0, full relock sequence.
- Undefined: `lock_s` low in RUN → FAULT directly; recovery only via `cfg_req` or reset.

## Test plan
- Startup, lock asserted 100 cycles after `pll_reset` falls (RST_HOLD=12, LOCK_STABLE=1200) -> `user_rst_n`/`clk_ok` rise 12+100+3+1200 cycles after reset release ±1; retry_cnt=0.
- `pll_lock` never asserts, MAX_RETRY=3 -> three HOLD pulses of 12 cycles, retry_cnt 1,2,3, `fault`=1 after third LOCK_WAIT expiry, `pll_reset` stays high.
- Lock glitches low 1 cycle at QUALIFY count 600 -> return to WAIT_LOCK, no retry increment, RUN reached only after fresh 1200-cycle stable window.
- In RUN, cfg_req with idsel=5, fbdsel=9, odsel=60 -> selects update next cycle, `pll_reset` pulses, single `cfg_ack` on RUN re-entry; `cfg_req` dropped next cycle.
- In RUN, drop `pll_lock` -> with PLL_CTRL_AUTO_RELOCK_EN: HOLD and relock; without: `fault`=1, then cfg_req recovers to RUN.
- Assert `sys_rst_n` low during QUALIFY with request pending -> all outputs at reset values next edge, no `cfg_ack` ever issued.
